// File: rtl/ninjin_ddr_sched.sv
// ninjin_ddr_sched: burst scheduler in front of the ninjin AXI image master.
// Arbitrates round-robin between a load job (drives ddr_re) and a store job
// (drives ddr_we). Each granted job is cut into BURST_LEN-word bursts. The
// master is strobed once per burst. The scheduler waits for burst_done before
// it advances the host/RAM addresses.
// Optional build macro NINJIN_SCHED_TIMEOUT_EN adds a watchdog on S_WAIT. If the
// master stays silent for TIMEOUT cycles, the job is aborted with job_err=1.
//
// Handshake: a requester raises *_req with *_haddr/*_raddr/*_nburst stable and
// holds them until *_ack pulses for one cycle. The fields are latched on the ack
// edge, so they may change from the ack cycle onward. Dropping *_req before ack
// is legal and withdraws the job. *_done pulses once per accepted job, and
// job_err is valid only in that cycle.
module ninjin_ddr_sched #(
    parameter int BURST_LEN = 256,
    parameter int DWIDTH    = 32,
    parameter int MEMSIZE   = 12,
    parameter int HADDR     = 32,
    parameter int NBW       = 8,
    parameter int TIMEOUT   = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_req,
    input  logic [HADDR-1:0]   ld_haddr,
    input  logic [MEMSIZE-1:0] ld_raddr,
    input  logic [NBW-1:0]     ld_nburst,
    output logic               ld_ack,
    output logic               ld_done,
    input  logic               st_req,
    input  logic [HADDR-1:0]   st_haddr,
    input  logic [MEMSIZE-1:0] st_raddr,
    input  logic [NBW-1:0]     st_nburst,
    output logic               st_ack,
    output logic               st_done,
    output logic               job_err,
    output logic               ddr_re,
    output logic               ddr_we,
    output logic [MEMSIZE-1:0] ddr_base,
    output logic [HADDR-1:0]   host_addr,
    input  logic               burst_done,
    input  logic [3:0]         err,
    output logic               busy,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [HADDR-1:0]   HSTEP = HADDR'(BURST_LEN * DWIDTH / 8);
    localparam logic [MEMSIZE-1:0] RSTEP = MEMSIZE'(BURST_LEN);

    state_t         state;
    logic           dir;        // 0 = load job, 1 = store job
    logic           rr_last;    // direction of the last finished job
    logic           abort;      // sticky error for the running job
    logic [NBW-1:0] remaining;  // bursts still to complete, including the current one
    logic           pick_st;

`ifdef NINJIN_SCHED_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WD_LIM = WDW'(TIMEOUT - 1);
    logic [WDW-1:0] wd_cnt;
`else
    // Keeps the watchdog limit referenced when the watchdog is not built.
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    // The store job wins only when load is idle or load won the previous job.
    assign pick_st   = st_req & (~ld_req | ~rr_last);
    assign state_dbg = state;

    // Scheduler FSM with all handshake and strobe outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            dir       <= 1'b0;
            rr_last   <= 1'b1;
            abort     <= 1'b0;
            remaining <= '0;
            ld_ack    <= 1'b0;
            ld_done   <= 1'b0;
            st_ack    <= 1'b0;
            st_done   <= 1'b0;
            job_err   <= 1'b0;
            ddr_re    <= 1'b0;
            ddr_we    <= 1'b0;
            ddr_base  <= '0;
            host_addr <= '0;
            busy      <= 1'b0;
`ifdef NINJIN_SCHED_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
        end else begin
            ld_ack  <= 1'b0;
            st_ack  <= 1'b0;
            ld_done <= 1'b0;
            st_done <= 1'b0;
            job_err <= 1'b0;
            ddr_re  <= 1'b0;
            ddr_we  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ld_req || st_req) begin
                        dir       <= pick_st;
                        ld_ack    <= ~pick_st;
                        st_ack    <= pick_st;
                        host_addr <= pick_st ? st_haddr  : ld_haddr;
                        ddr_base  <= pick_st ? st_raddr  : ld_raddr;
                        remaining <= pick_st ? st_nburst : ld_nburst;
                        abort     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    state <= (remaining == '0) ? S_DONE : S_ISSUE;
                end
                S_ISSUE: begin
                    ddr_re <= ~dir;
                    ddr_we <= dir;
`ifdef NINJIN_SCHED_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (burst_done) begin
                        if (err != 4'h0) begin
                            abort <= 1'b1;
                            state <= S_DONE;
                        end else if (remaining == NBW'(1)) begin
                            state <= S_DONE;
                        end else begin
                            remaining <= remaining - 1'b1;
                            host_addr <= host_addr + HSTEP;
                            ddr_base  <= ddr_base + RSTEP;
                            state     <= S_ISSUE;
                        end
                    end
`ifdef NINJIN_SCHED_TIMEOUT_EN
                    else if (wd_cnt == WD_LIM) begin
                        abort <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`else
                    // Without the watchdog the master is trusted to answer.
`endif
                end
                S_DONE: begin
                    ld_done <= ~dir;
                    st_done <= dir;
                    job_err <= abort;
                    rr_last <= dir;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ninjin_ddr_sched.sv
// Directed bench for ninjin_ddr_sched: reset values, multi-burst load, round-robin
// arbitration, error abort, zero-length job, address wrap and reset mid-job.
// A behavioural master answers each strobe with burst_done after resp_delay cycles.
module tb_ninjin_ddr_sched;

`ifdef NINJIN_SCHED_TIMEOUT_EN
  localparam int TO = 64;
`else
  localparam int TO = 4096;
`endif

  logic        clk, rst;
  logic        ld_req, st_req, ld_ack, st_ack, ld_done, st_done, job_err;
  logic [31:0] ld_haddr, st_haddr, host_addr;
  logic [11:0] ld_raddr, st_raddr, ddr_base;
  logic [7:0]  ld_nburst, st_nburst;
  logic        ddr_re, ddr_we, burst_done, busy;
  logic [3:0]  err;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // behavioural master
  int         resp_delay = 20;
  bit         resp_en    = 1'b1;
  int         err_idx    = -1;
  logic [3:0] err_val    = 4'h0;
  int         resp_cnt   = 0;
  int         resp_idx   = 0;
  int         bd_cyc     = -1;

  // observation logs
  int          sb_cyc[$];
  logic        sb_dir[$];
  logic [11:0] sb_base[$];
  logic [31:0] sb_host[$];
  int          ack_cyc[$];
  logic        ack_dir[$];
  int          done_cyc[$];
  logic        done_dir[$];
  logic        done_err[$];

  ninjin_ddr_sched #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_haddr(ld_haddr), .ld_raddr(ld_raddr), .ld_nburst(ld_nburst),
    .ld_ack(ld_ack), .ld_done(ld_done),
    .st_req(st_req), .st_haddr(st_haddr), .st_raddr(st_raddr), .st_nburst(st_nburst),
    .st_ack(st_ack), .st_done(st_done),
    .job_err(job_err), .ddr_re(ddr_re), .ddr_we(ddr_we),
    .ddr_base(ddr_base), .host_addr(host_addr),
    .burst_done(burst_done), .err(err), .busy(busy), .state_dbg(state_dbg)
  );

  // clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // master model: one burst_done per strobe, optional error on burst err_idx
  always @(negedge clk) begin
    burst_done = 1'b0;
    err = 4'h0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        burst_done = 1'b1;
        err = (resp_idx == err_idx) ? err_val : 4'h0;
        resp_idx++;
        bd_cyc = cyc;
      end
    end
    if (resp_en && (ddr_re || ddr_we)) resp_cnt = resp_delay;
  end

  // monitor
  always @(negedge clk) begin
    if (ddr_re || ddr_we) begin
      sb_cyc.push_back(cyc); sb_dir.push_back(ddr_we);
      sb_base.push_back(ddr_base); sb_host.push_back(host_addr);
    end
    if (ld_ack || st_ack) begin
      ack_cyc.push_back(cyc); ack_dir.push_back(st_ack);
    end
    if (ld_done || st_done) begin
      done_cyc.push_back(cyc); done_dir.push_back(st_done); done_err.push_back(job_err);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int n, input int limit, output bit ok);
    int seen = 0;
    int k = 0;
    while (k < limit && seen < n) begin
      @(negedge clk);
      k++;
      if (ld_ack) ld_req = 1'b0;
      if (st_ack) st_req = 1'b0;
      if (ld_done || st_done) seen++;
    end
    ok = (seen == n);
    #1;
  endtask

  task automatic test_reset;
    ld_req = 0; st_req = 0; ld_haddr = '0; st_haddr = '0; ld_raddr = '0; st_raddr = '0;
    ld_nburst = '0; st_nburst = '0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ld_ack, ld_done, st_ack, st_done, job_err, ddr_re, ddr_we, busy} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {ld_ack, ld_done, st_ack, st_done, job_err, ddr_re, ddr_we, busy});
    end
    n_checks++;
    if (ddr_base !== 12'h000 || host_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr: got base %h host %h expected 000 00000000", ddr_base, host_addr);
    end
    tick(2); rst = 1'b0; tick(2);
    n_checks++;
    if (state_dbg !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got state %0d busy %b expected 0 0", state_dbg, busy);
    end
  endtask

  task automatic test_load_three;
    logic [31:0] exp_q[$];
    logic [11:0] exp_b[$];
    int s0 = sb_cyc.size();
    int a0 = ack_cyc.size();
    int d0 = done_cyc.size();
    int rc;
    bit ok;
    exp_q = '{32'h1000_0000, 32'h1000_0400, 32'h1000_0800};
    exp_b = '{12'd0, 12'd256, 12'd512};
    err_idx = -1; resp_delay = 20;
    @(negedge clk);
    ld_haddr = 32'h1000_0000; ld_raddr = 12'h000; ld_nburst = 8'd3; ld_req = 1'b1; rc = cyc;
    wait_done(1, 400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL t1_timeout: got no ld_done expected one within 400 cycles"); end
    n_checks++;
    if (ack_cyc.size() != a0 + 1 || ack_cyc[a0] - rc != 1 || ack_dir[a0] !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_ack: got %0d acks latency %0d expected 1 ld ack latency 1",
               ack_cyc.size() - a0, ack_cyc[a0] - rc);
    end
    n_checks++;
    if (sb_cyc.size() - s0 != 3) begin
      n_fail++; $display("FAIL t1_strobe_count: got %0d expected 3", sb_cyc.size() - s0);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (sb_dir[s0+i] !== 1'b0 || sb_host[s0+i] !== exp_q[i] || sb_base[s0+i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL t1_burst%0d: got we=%b host %h base %h expected re host %h base %h",
                 i, sb_dir[s0+i], sb_host[s0+i], sb_base[s0+i], exp_q[i], exp_b[i]);
      end
    end
    n_checks++;
    if (sb_cyc[s0] - ack_cyc[a0] != 2) begin
      n_fail++; $display("FAIL t1_first_strobe: got %0d cycles after ack expected 2", sb_cyc[s0] - ack_cyc[a0]);
    end
    n_checks++;
    if (done_dir[d0] !== 1'b0 || done_err[d0] !== 1'b0) begin
      n_fail++; $display("FAIL t1_done: got st=%b err=%b expected ld_done err=0", done_dir[d0], done_err[d0]);
    end
    n_checks++;
    if (done_cyc[d0] - bd_cyc < 1 || done_cyc[d0] - bd_cyc > 2) begin
      n_fail++; $display("FAIL t1_done_latency: got %0d expected 1..2", done_cyc[d0] - bd_cyc);
    end
  endtask

  task automatic test_arbitration;
    logic [31:0] exp_q[$];
    logic [11:0] exp_b[$];
    logic        exp_d[$];
    int s0 = sb_cyc.size();
    int a0 = ack_cyc.size();
    int d0 = done_cyc.size();
    int lacks = 0;
    int k = 0;
    exp_q = '{32'hA000_0000, 32'hB000_0000, 32'hA100_0000};
    exp_b = '{12'h010, 12'h020, 12'h030};
    exp_d = '{1'b0, 1'b1, 1'b0};
    err_idx = -1; resp_delay = 3;
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
    @(negedge clk);
    ld_haddr = 32'hA000_0000; ld_raddr = 12'h010; ld_nburst = 8'd1; ld_req = 1'b1;
    st_haddr = 32'hB000_0000; st_raddr = 12'h020; st_nburst = 8'd1; st_req = 1'b1;
    while (k < 300 && done_cyc.size() < d0 + 3) begin
      @(negedge clk);
      k++;
      if (ld_ack) begin
        lacks++;
        if (lacks == 1) begin ld_haddr = 32'hA100_0000; ld_raddr = 12'h030; end
        else ld_req = 1'b0;
      end
      if (st_ack) st_req = 1'b0;
    end
    #1;
    n_checks++;
    if (done_cyc.size() != d0 + 3 || ack_cyc.size() != a0 + 3) begin
      n_fail++;
      $display("FAIL t2_counts: got %0d acks %0d dones expected 3 3", ack_cyc.size() - a0, done_cyc.size() - d0);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ack_dir[a0+i] !== exp_d[i] || done_dir[d0+i] !== exp_d[i] || done_err[d0+i] !== 1'b0) begin
        n_fail++;
        $display("FAIL t2_order%0d: got ack st=%b done st=%b err=%b expected st=%b err=0",
                 i, ack_dir[a0+i], done_dir[d0+i], done_err[d0+i], exp_d[i]);
      end
      n_checks++;
      if (sb_dir[s0+i] !== exp_d[i] || sb_host[s0+i] !== exp_q[i] || sb_base[s0+i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL t2_burst%0d: got we=%b host %h base %h expected we=%b host %h base %h",
                 i, sb_dir[s0+i], sb_host[s0+i], sb_base[s0+i], exp_d[i], exp_q[i], exp_b[i]);
      end
    end
    n_checks++;
    if (ack_cyc[a0+1] - done_cyc[d0] != 1) begin
      n_fail++; $display("FAIL t2_idle_gap: got ack %0d cycles after done expected 1", ack_cyc[a0+1] - done_cyc[d0]);
    end
  endtask

  task automatic test_store_error;
    int s0 = sb_cyc.size();
    int d0 = done_cyc.size();
    bit ok;
    resp_delay = 5; err_idx = resp_idx + 1; err_val = 4'b0101;
    @(negedge clk);
    st_haddr = 32'h2000_0000; st_raddr = 12'h100; st_nburst = 8'd4; st_req = 1'b1;
    wait_done(1, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL t3_timeout: got no st_done expected one within 200 cycles"); end
    tick(1);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL t3_busy: got %b after done expected 0", busy); end
    n_checks++;
    if (sb_cyc.size() - s0 != 2) begin
      n_fail++; $display("FAIL t3_strobe_count: got %0d expected 2", sb_cyc.size() - s0);
    end
    n_checks++;
    if (sb_dir[s0] !== 1'b1 || sb_dir[s0+1] !== 1'b1 || sb_base[s0+1] !== 12'h200 || sb_host[s0+1] !== 32'h2000_0400) begin
      n_fail++;
      $display("FAIL t3_bursts: got we %b%b base %h host %h expected we 11 base 200 host 20000400",
               sb_dir[s0], sb_dir[s0+1], sb_base[s0+1], sb_host[s0+1]);
    end
    n_checks++;
    if (done_dir[d0] !== 1'b1 || done_err[d0] !== 1'b1) begin
      n_fail++; $display("FAIL t3_done: got st=%b err=%b expected st_done err=1", done_dir[d0], done_err[d0]);
    end
    err_idx = -1;
  endtask

  task automatic test_zero_and_wrap;
    int s0 = sb_cyc.size();
    int a0 = ack_cyc.size();
    int d0 = done_cyc.size();
    bit ok;
    err_idx = -1; resp_delay = 4;
    @(negedge clk);
    ld_haddr = 32'h3000_0000; ld_raddr = 12'h055; ld_nburst = 8'd0; ld_req = 1'b1;
    wait_done(1, 50, ok);
    n_checks++;
    if (!ok || sb_cyc.size() != s0) begin
      n_fail++; $display("FAIL t4_zero: got done=%b strobes %0d expected done, 0 strobes", ok, sb_cyc.size() - s0);
    end
    n_checks++;
    if (done_cyc[d0] - ack_cyc[a0] != 2 || done_err[d0] !== 1'b0 || done_dir[d0] !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_zero_done: got latency %0d err %b st %b expected 2 0 0",
               done_cyc[d0] - ack_cyc[a0], done_err[d0], done_dir[d0]);
    end
    s0 = sb_cyc.size(); d0 = done_cyc.size();
    @(negedge clk);
    st_haddr = 32'hFFFF_FC00; st_raddr = 12'hF00; st_nburst = 8'd2; st_req = 1'b1;
    wait_done(1, 100, ok);
    n_checks++;
    if (!ok || sb_cyc.size() - s0 != 2) begin
      n_fail++; $display("FAIL t4_wrap_count: got done=%b strobes %0d expected done, 2", ok, sb_cyc.size() - s0);
    end
    n_checks++;
    if (sb_base[s0] !== 12'hF00 || sb_base[s0+1] !== 12'h000 ||
        sb_host[s0] !== 32'hFFFF_FC00 || sb_host[s0+1] !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL t4_wrap_addr: got base %h/%h host %h/%h expected f00/000 fffffc00/00000000",
               sb_base[s0], sb_base[s0+1], sb_host[s0], sb_host[s0+1]);
    end
    n_checks++;
    if (done_err[d0] !== 1'b0 || done_dir[d0] !== 1'b1) begin
      n_fail++; $display("FAIL t4_wrap_done: got err %b st %b expected 0 1", done_err[d0], done_dir[d0]);
    end
  endtask

  task automatic test_reset_midjob;
    int s0 = sb_cyc.size();
    int d0 = done_cyc.size();
    int k = 0;
    bit ok;
    resp_en = 1'b0;
    @(negedge clk);
    ld_haddr = 32'h4000_0000; ld_raddr = 12'h040; ld_nburst = 8'd2; ld_req = 1'b1;
    while (k < 20 && !ddr_re) begin
      @(negedge clk);
      k++;
      if (ld_ack) ld_req = 1'b0;
    end
    n_checks++;
    if (!ddr_re) begin n_fail++; $display("FAIL t5_strobe: got no ddr_re expected one within 20 cycles"); end
    tick(3);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ld_ack, ld_done, st_ack, st_done, job_err, ddr_re, ddr_we, busy} !== 8'h00 ||
        ddr_base !== 12'h000 || host_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL t5_reset_outputs: got ctrl %b base %h host %h expected all zero",
               {ld_ack, ld_done, st_ack, st_done, job_err, ddr_re, ddr_we, busy}, ddr_base, host_addr);
    end
    tick(2); rst = 1'b0; resp_en = 1'b1; tick(30);
    n_checks++;
    if (done_cyc.size() != d0 || sb_cyc.size() != s0 + 1) begin
      n_fail++;
      $display("FAIL t5_no_done: got %0d dones %0d strobes expected 0 1", done_cyc.size() - d0, sb_cyc.size() - s0);
    end
    s0 = sb_cyc.size();
    resp_delay = 3;
    @(negedge clk);
    ld_nburst = 8'd1; ld_req = 1'b1;
    wait_done(1, 50, ok);
    n_checks++;
    if (!ok || done_err[d0] !== 1'b0 || sb_base[s0] !== 12'h040 || sb_host[s0] !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL t5_reissue: got done=%b err %b base %h host %h expected 1 0 040 40000000",
               ok, done_err[d0], sb_base[s0], sb_host[s0]);
    end
  endtask

`ifdef NINJIN_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int s0 = sb_cyc.size();
    int d0 = done_cyc.size();
    bit ok;
    resp_en = 1'b0;
    @(negedge clk);
    ld_haddr = 32'h5000_0000; ld_raddr = 12'h000; ld_nburst = 8'd3; ld_req = 1'b1;
    wait_done(1, 200, ok);
    n_checks++;
    if (!ok || sb_cyc.size() - s0 != 1 || done_err[d0] !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_timeout: got done=%b strobes %0d err %b expected 1 1 1", ok, sb_cyc.size() - s0, done_err[d0]);
    end
    n_checks++;
    if (done_cyc[d0] - sb_cyc[s0] < TO || done_cyc[d0] - sb_cyc[s0] > TO + 1) begin
      n_fail++; $display("FAIL t6_timeout_latency: got %0d expected %0d..%0d", done_cyc[d0] - sb_cyc[s0], TO, TO + 1);
    end
    resp_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_load_three();
    test_arbitration();
    test_store_error();
    test_zero_and_wrap();
    test_reset_midjob();
`ifdef NINJIN_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
